// File: rtl/system_types_pkg.sv
// Shared arbiter types: default per-requester weight width and the weight typedef.
package system_types_pkg;

    localparam int ARB_WEIGHT_WIDTH = 3;

    typedef logic [ARB_WEIGHT_WIDTH-1:0] arb_weight_t;

endpackage

// File: rtl/rr_priority_select.sv
// Rotating first-set search: lowest requesting index at or above ptr, else
// wrap around to the lowest requesting index overall.
module rr_priority_select #(
    parameter int N  = 4,
    parameter int LW = 2
) (
    input  logic [N-1:0]  req_vec,
    input  logic [LW-1:0] ptr,
    output logic          found,
    output logic [LW-1:0] sel
);

    logic          hi_found;
    logic [LW-1:0] hi_sel;
    logic [LW-1:0] lo_sel;

    // Scanning downward leaves the lowest hit in each half.
    always_comb begin
        hi_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                lo_sel = LW'(i);
                if (i >= int'(ptr)) begin
                    hi_sel   = LW'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign found = |req_vec;
    assign sel   = hi_found ? hi_sel : lo_sel;

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: each grant holder keeps priority for up to its
// weight in accepts. Optional grant lock is enabled by ARBITER_WRR_LOCK_EN.
module arbiter_wrr
    import system_types_pkg::*;
#(
    parameter int REQUESTER_COUNT     = 4,
    parameter int LOG_REQUESTER_COUNT = $clog2(REQUESTER_COUNT),
    parameter int WEIGHT_WIDTH        = ARB_WEIGHT_WIDTH
) (
    input  logic                                    CLK,
    input  logic                                    nRST,
    input  logic [REQUESTER_COUNT-1:0]              req_vec,
    input  logic [REQUESTER_COUNT*WEIGHT_WIDTH-1:0] weight_vec,
    input  logic                                    lock_req,
    output logic                                    req_present,
    input  logic                                    ack_ready,
    output logic [REQUESTER_COUNT-1:0]              ack_one_hot,
    output logic [LOG_REQUESTER_COUNT-1:0]          ack_index
);

    localparam int LW = LOG_REQUESTER_COUNT;
    localparam int CW = WEIGHT_WIDTH + 1;

    logic [LW-1:0]           ptr, ptr_nxt;
    logic [WEIGHT_WIDTH-1:0] burst_cnt, burst_nxt;
    logic [LW-1:0]           rr_sel, sel, sel_inc;
    logic                    found;
    logic                    accept;
    logic [WEIGHT_WIDTH-1:0] w_raw;
    logic [CW-1:0]           w_eff;
    logic [CW-1:0]           count;
    logic                    continue_burst;

    rr_priority_select #(
        .N  (REQUESTER_COUNT),
        .LW (LW)
    ) u_sel (
        .req_vec (req_vec),
        .ptr     (ptr),
        .found   (found),
        .sel     (rr_sel)
    );

`ifdef ARBITER_WRR_LOCK_EN
    logic lock_valid, lock_nxt;
    logic ptr_req;

    always_comb begin
        ptr_req = 1'b0;
        for (int i = 0; i < REQUESTER_COUNT; i++)
            if (ptr == LW'(i)) ptr_req = req_vec[i];
    end

    // A live lock pins selection to the holder regardless of its weight.
    assign sel = (lock_valid && ptr_req) ? ptr : rr_sel;
`else
    logic unused_lock_req;
    assign unused_lock_req = lock_req;
    assign sel             = rr_sel;
`endif

    assign req_present = found;
    assign accept      = ack_ready & found;
    assign ack_index   = found ? sel : '0;

    always_comb begin
        ack_one_hot = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++)
            ack_one_hot[i] = found && ack_ready && (sel == LW'(i));
    end

    always_comb begin
        w_raw = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++)
            if (sel == LW'(i)) w_raw = weight_vec[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    // Zero weight still earns one grant per turn.
    assign w_eff   = (w_raw == '0) ? CW'(1) : {1'b0, w_raw};
    assign sel_inc = (sel == LW'(REQUESTER_COUNT - 1)) ? '0 : sel + LW'(1);

    // Credit only accumulates while the same requester stays at ptr.
    always_comb begin
        count = CW'(1);
`ifdef ARBITER_WRR_LOCK_EN
        if (!lock_valid && sel == ptr) count = {1'b0, burst_cnt} + CW'(1);
`else
        if (sel == ptr) count = {1'b0, burst_cnt} + CW'(1);
`endif
    end

    assign continue_burst = (count < w_eff);

    always_comb begin
        ptr_nxt   = ptr;
        burst_nxt = burst_cnt;
        if (accept) begin
            if (continue_burst) begin
                ptr_nxt   = sel;
                burst_nxt = count[WEIGHT_WIDTH-1:0];
            end else begin
                ptr_nxt   = sel_inc;
                burst_nxt = '0;
            end
        end
`ifdef ARBITER_WRR_LOCK_EN
        if (accept && lock_req) begin
            ptr_nxt   = sel;
            burst_nxt = '0;
        end
`endif
    end

`ifdef ARBITER_WRR_LOCK_EN
    always_comb begin
        lock_nxt = lock_valid;
        if (accept)
            lock_nxt = lock_req;
        else if (lock_valid && !ptr_req)
            lock_nxt = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) lock_valid <= 1'b0;
        else       lock_valid <= lock_nxt;
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            ptr       <= ptr_nxt;
            burst_cnt <= burst_nxt;
        end
    end

endmodule

// File: tb/tb_arbiter_wrr.sv
// Bench for arbiter_wrr (4 requesters, 3-bit weights): directed sequences plus
// randomized traffic against a turn/credit reference model.
module tb_arbiter_wrr;
    import system_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [3:0]  req_vec;
    logic [11:0] weight_vec;
    logic        lock_req;
    logic        req_present;
    logic        ack_ready;
    logic [3:0]  ack_one_hot;
    logic [1:0]  ack_index;

    int n_cmp = 0;
    int n_err = 0;

    // Model: whose turn it is, and how many grants that requester has used.
    int turn    = 0;
    int used    = 0;

    arbiter_wrr #(
        .REQUESTER_COUNT (4),
        .WEIGHT_WIDTH    (3)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .req_vec     (req_vec),
        .weight_vec  (weight_vec),
        .lock_req    (lock_req),
        .req_present (req_present),
        .ack_ready   (ack_ready),
        .ack_one_hot (ack_one_hot),
        .ack_index   (ack_index)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Next requester in circular order starting from the current turn.
    function automatic int m_pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            int idx = (turn + k) % 4;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic int m_weight(input logic [11:0] w, input int who);
        arb_weight_t wt;
        wt = arb_weight_t'(w >> (3 * who));
        return (wt == 0) ? 1 : int'(wt);
    endfunction

    task automatic m_grant(input int who, input logic [11:0] w);
        int grants;
        grants = (who == turn) ? used + 1 : 1;
        if (grants < m_weight(w, who)) begin
            turn = who;
            used = grants;
        end else begin
            turn = (who + 1) % 4;
            used = 0;
        end
    endtask

    // Drive one cycle (entered at posedge+1), check outputs, then advance model.
    task automatic step(input logic [3:0] r, input logic [11:0] w, input logic a,
                        input int exp_idx, input int exp_oh);
        int who;
        req_vec    = r;
        weight_vec = w;
        ack_ready  = a;
        #1;
        who = m_pick(r);
        chk("present", int'(req_present), (r != 0) ? 1 : 0);
        chk("index",   int'(ack_index),   (r != 0) ? who : 0);
        chk("onehot",  int'(ack_one_hot), (r != 0 && a) ? (1 << who) : 0);
        if (exp_idx >= 0) chk("dir_index",  int'(ack_index),   exp_idx);
        if (exp_oh  >= 0) chk("dir_onehot", int'(ack_one_hot), exp_oh);
        @(posedge CLK);
        if (a && r != 0) m_grant(who, w);
        #1;
    endtask

    task automatic pulse_reset();
        req_vec   = 4'b1111;
        ack_ready = 1'b1;
        nRST      = 1'b0;
        #1;
        turn = 0;
        used = 0;
        chk("rst_index",  int'(ack_index),   0);
        chk("rst_onehot", int'(ack_one_hot), 1);
        nRST = 1'b1;
    endtask

    initial begin
        nRST       = 1'b0;
        req_vec    = 4'b1111;
        weight_vec = 12'o1111;
        ack_ready  = 1'b1;
        lock_req   = 1'b0;
        #1;
        chk("rst_present", int'(req_present), 1);
        chk("rst_index",   int'(ack_index),   0);
        chk("rst_onehot",  int'(ack_one_hot), 1);
        @(posedge CLK);
        #1;
        chk("rst_hold_index", int'(ack_index), 0);
        nRST = 1'b1;

        // Plain round robin with unit weights.
        step(4'b1111, 12'o1111, 1'b1, 0, 1);
        step(4'b1111, 12'o1111, 1'b1, 1, 2);
        step(4'b1111, 12'o1111, 1'b1, 2, 4);
        step(4'b1111, 12'o1111, 1'b1, 3, 8);
        step(4'b1111, 12'o1111, 1'b1, 0, 1);
        pulse_reset();

        // Requester 0 weighted 3.
        step(4'b1111, 12'o1113, 1'b1, 0, -1);
        step(4'b1111, 12'o1113, 1'b1, 0, -1);
        step(4'b1111, 12'o1113, 1'b1, 0, -1);
        step(4'b1111, 12'o1113, 1'b1, 1, -1);
        step(4'b1111, 12'o1113, 1'b1, 2, -1);
        step(4'b1111, 12'o1113, 1'b1, 3, -1);
        step(4'b1111, 12'o1113, 1'b1, 0, -1);
        pulse_reset();

        // Stall mid-burst freezes state.
        step(4'b1111, 12'o1112, 1'b1, 0, 1);
        step(4'b1111, 12'o1112, 1'b0, 0, 0);
        step(4'b1111, 12'o1112, 1'b0, 0, 0);
        step(4'b1111, 12'o1112, 1'b1, 0, 1);
        step(4'b1111, 12'o1112, 1'b1, 1, 2);
        pulse_reset();

        // Holder drops mid-burst, then a zero weight acts as one.
        step(4'b1111, 12'o1131, 1'b1, 0, -1);
        step(4'b1111, 12'o1131, 1'b1, 1, -1);
        step(4'b1101, 12'o1131, 1'b1, 2, -1);
        step(4'b1101, 12'o1131, 1'b1, 3, -1);
        step(4'b1101, 12'o0131, 1'b1, 0, -1);
        step(4'b1101, 12'o0131, 1'b1, 2, -1);
        step(4'b1101, 12'o0131, 1'b1, 3, -1);
        step(4'b1101, 12'o0131, 1'b1, 0, -1);
        pulse_reset();

        // Idle cycles hold a burst; reset mid-burst restarts from requester 0.
        step(4'b1111, 12'o1113, 1'b1, 0, -1);
        step(4'b0000, 12'o1113, 1'b1, 0, 0);
        step(4'b0000, 12'o1113, 1'b1, 0, 0);
        step(4'b1111, 12'o1113, 1'b1, 0, -1);
        pulse_reset();
        step(4'b1111, 12'o1113, 1'b1, 0, -1);
        step(4'b1111, 12'o1113, 1'b1, 0, -1);
        step(4'b1111, 12'o1113, 1'b1, 0, -1);
        step(4'b1111, 12'o1113, 1'b1, 1, -1);

        // Random traffic; lock_req must have no effect in this build.
        begin
            logic [11:0] w;
            w = 12'($urandom);
            for (int n = 0; n < 600; n++) begin
                if (n % 20 == 0) w = 12'($urandom);
                lock_req = 1'($urandom);
                step(4'($urandom), w, ($urandom_range(0, 3) != 0), -1, -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
